// File: rtl/uart_tx.sv
// uart_tx: 8N-parity-1 serial transmitter with a small byte FIFO in front.
// Ports: clk, reset (async, active-low), data_in/wr_en/full (FIFO side), tx/busy/tx_done (line side).
module uart_tx #(
  parameter int BAUD_RATE = 4,
  parameter int PARITY    = 0,
  parameter int FIFO_AW   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       wr_en,
  output logic       full,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int BIT_LAST_I = 2 * BAUD_RATE - 1;
  localparam logic [5:0] BIT_LAST = BIT_LAST_I[5:0];
  localparam logic [FIFO_AW:0] CNT_FULL = DEPTH[FIFO_AW:0];
  localparam logic [FIFO_AW:0] CNT_ONE = 1;
  localparam logic [FIFO_AW-1:0] PTR_ONE = 1;
  localparam logic PAR_ODD = (PARITY != 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0] state_q, state_d;
  logic [5:0] clk_cnt_q, clk_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       full_q, full_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic [7:0] mem_q [DEPTH];

  logic       push;
  logic       pop;
  logic       empty;
  logic       bit_end;
  logic [7:0] head;

  assign push    = wr_en && !full_q;
  assign empty   = (count_q == '0);
  assign bit_end = (clk_cnt_q == BIT_LAST);
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + 6'd1;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    pop       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          // Chain straight into the next start bit when more data waits.
          if (!empty) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        clk_cnt_d = '0;
        state_d   = S_IDLE;
      end
    endcase

    if (pop) begin
      shift_d   = head;
      bit_cnt_d = '0;
      par_d     = (^head) ^ PAR_ODD;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    full_d = (count_d == CNT_FULL);
  end

  // Line outputs are decoded from the next state so they are registered
  // yet change on the same edge as the state itself.
  always_comb begin
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_STOP) && (clk_cnt_d == BIT_LAST);
    tx_d   = 1'b1;
    unique case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      full_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      full_q    <= full_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

  assign full    = full_q;
  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter for the inter-module Ethernet-cable links: each FPGA sends 8-bit trigger/data words to its peer module's receiver and loops received words back. Frames are 11 bits: start, 8 data bits LSB-first, parity, one stop bit. Bytes are queued in a small internal FIFO, so the controller can burst words without waiting for each frame to finish.

## Interface
- BAUD_RATE, default 4: half-bit period in clk cycles. One bit lasts 2·BAUD_RATE clocks; 4 gives 6 Mbaud at 48 MHz. Legal range is 1–32.
- PARITY, default 0: 0 = even parity, 1 = odd parity.
- FIFO_AW, default 2: FIFO address width. Depth is 2^FIFO_AW, so 4 entries by default.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- data_in  in  8  byte to queue.
- wr_en  in  1  write strobe. Accepted only when full=0.
- full  out  1  FIFO holds 2^FIFO_AW entries.
- tx  out  1  serial line, registered. Idle is high.
- busy  out  1  a frame is on the line.
- tx_done  out  1  one-cycle pulse in the last clock of each stop bit.

## Operation
- Reset (reset=0, asynchronous) forces:
  - tx=1, busy=0, tx_done=0, full=0;
  - FIFO empty, FSM in IDLE;
  - any partial frame is abandoned immediately.
- FIFO: write pointer, read pointer and an occupancy count of FIFO_AW+1 bits.
  - A write with full=1 is dropped with no side effects, even if a pop happens on the same edge.
  - A simultaneous push and pop when not full leaves the count unchanged.
  - Pointers wrap modulo depth.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when the FIFO is non-empty. On that edge: pop the byte into the shift register, clear the bit counter, compute the parity bit as ^byte XOR PARITY.
  - START: tx=0 for 2·BAUD_RATE clocks, then go to DATA.
  - DATA: tx = shift[0]. Shift right every 2·BAUD_RATE clocks. After bit 7, go to PARITY.
  - PARITY: tx = parity bit for 2·BAUD_RATE clocks, then go to STOP.
  - STOP: tx=1 for 2·BAUD_RATE clocks. On the last clock, tx_done=1. Then:
    - if the FIFO is non-empty, pop and go to START directly, with no idle gap;
    - otherwise go to IDLE.
- Clock counter: 6 bits. It reloads to 0 at every bit boundary.
- busy=1 in the START, DATA, PARITY and STOP states.
- The parity rule matches the receiver: the XOR of the 8 data bits and the parity bit is 0 for even parity and 1 for odd.

## Timing
- Latency from an idle line:
  - write accepted at edge N → FIFO non-empty after N;
  - FSM leaves IDLE at edge N+1;
  - tx falls after edge N+1 (registered output), along with busy=1.
- Frame length is exactly 22·BAUD_RATE clocks. Back-to-back frames are contiguous: the next start bit begins in the clock after the tx_done pulse.
- full is updated on the same edge as the push or pop that changes the count.
- tx_done and busy are registered and glitch-free. tx_done never stays high for two consecutive cycles.
- Reset asserted mid-frame: tx=1 asynchronously. After release, the FSM waits in IDLE for a new write; no data is retained.

## Test plan
- BAUD_RATE=4, PARITY=0, write 0xA5:
  - line shows 0,1,0,1,0,0,1,0,1,0,1 with each bit held 8 clocks;
  - tx falls 2 edges after the write;
  - tx_done pulses once, 88 clocks after tx falls.
- PARITY=0, 0x01 → parity bit 1. PARITY=1, 0x00 → parity bit 1. PARITY=1, 0xFF → parity bit 1.
- Six consecutive writes A..F from idle:
  - A is popped at once; B..E fill the FIFO; full=1 after the 5th write;
  - F is dropped;
  - line carries A,B,C,D,E back-to-back over 440 clocks with no idle gaps;
  - five tx_done pulses; busy falls after E's stop bit.
- Loopback: connect tx to the uart_rx input, with matching BAUD_RATE/PARITY:
  - 0x00..0x3F received in order;
  - parity_error never asserted;
  - each rx_done occurs before the corresponding tx_done.
- Assert reset at clock 30 of a frame:
  - tx=1 and busy=0 within the same cycle;
  - FIFO empty, full=0;
  - a new write 0x3C after release transmits cleanly.
- Write at edge N while the FSM pops and count=3:
  - count stays 3, full stays 0;
  - both bytes are transmitted in order.
